// File: rtl/p_shift_state_iter.sv
// Iterative RECTANGLE ShiftRow: rotates rows 1..3 by one bit per cycle in either direction.
// Optional macro RECT_SHIFT_SHORTEST_EN makes each row take the shorter rotation path.
module p_shift_state_iter #(
  parameter int W  = 16,
  parameter int R1 = 1,
  parameter int R2 = 12,
  parameter int R3 = 13
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_start,
  input  logic         i_dec,
  input  logic [W-1:0] iv_state0,
  input  logic [W-1:0] iv_state1,
  input  logic [W-1:0] iv_state2,
  input  logic [W-1:0] iv_state3,
  output logic [W-1:0] ov_state0,
  output logic [W-1:0] ov_state1,
  output logic [W-1:0] ov_state2,
  output logic [W-1:0] ov_state3,
  output logic         o_busy,
  output logic         o_done
);

  localparam int CW = $clog2(W) + 1;

`ifdef RECT_SHIFT_SHORTEST_EN
  localparam int   S1   = ((W - R1) < R1) ? (W - R1) : R1;
  localparam int   S2   = ((W - R2) < R2) ? (W - R2) : R2;
  localparam int   S3   = ((W - R3) < R3) ? (W - R3) : R3;
  localparam logic REV1 = ((W - R1) < R1);
  localparam logic REV2 = ((W - R2) < R2);
  localparam logic REV3 = ((W - R3) < R3);
`else
  localparam int   S1   = R1;
  localparam int   S2   = R2;
  localparam int   S3   = R3;
  localparam logic REV1 = 1'b0;
  localparam logic REV2 = 1'b0;
  localparam logic REV3 = 1'b0;
`endif

  localparam int L12 = (S1 > S2) ? S1 : S2;
  localparam int L3  = (L12 > S3) ? L12 : S3;
  localparam int L   = (L3 > 1) ? L3 : 1;

  localparam logic [CW-1:0] S1_C  = CW'(S1);
  localparam logic [CW-1:0] S2_C  = CW'(S2);
  localparam logic [CW-1:0] S3_C  = CW'(S3);
  localparam logic [CW-1:0] L_C   = CW'(L);
  localparam logic [CW-1:0] ONE_C = CW'(1);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  // One-bit rotation; left when dir_left=1, otherwise right.
  function automatic logic [W-1:0] rot1(input logic [W-1:0] x, input logic dir_left);
    if (dir_left) begin
      rot1 = {x[W-2:0], x[W-1]};
    end else begin
      rot1 = {x[0], x[W-1:1]};
    end
  endfunction

  logic [0:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
  logic          dec_q, dec_d;
  logic          done_q, done_d;
  logic [W-1:0]  row0_q, row0_d, row1_q, row1_d, row2_q, row2_d, row3_q, row3_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dec_d   = dec_q;
    done_d  = 1'b0;
    row0_d  = row0_q;
    row1_d  = row1_q;
    row2_d  = row2_q;
    row3_d  = row3_q;
    cnt_inc = cnt_q + ONE_C;
    case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          row0_d  = iv_state0;
          row1_d  = iv_state1;
          row2_d  = iv_state2;
          row3_d  = iv_state3;
          dec_d   = i_dec;
          cnt_d   = '0;
          state_d = ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        // Forward rotates left; a reversed (shorter-path) row flips that.
        if (cnt_q < S1_C) row1_d = rot1(row1_q, ~dec_q ^ REV1);
        else              row1_d = row1_q;
        if (cnt_q < S2_C) row2_d = rot1(row2_q, ~dec_q ^ REV2);
        else              row2_d = row2_q;
        if (cnt_q < S3_C) row3_d = rot1(row3_q, ~dec_q ^ REV3);
        else              row3_d = row3_q;
        cnt_d = cnt_inc;
        if (cnt_inc == L_C) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end else begin
          state_d = ST_RUN;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      dec_q   <= 1'b0;
      done_q  <= 1'b0;
      row0_q  <= '0;
      row1_q  <= '0;
      row2_q  <= '0;
      row3_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dec_q   <= dec_d;
      done_q  <= done_d;
      row0_q  <= row0_d;
      row1_q  <= row1_d;
      row2_q  <= row2_d;
      row3_q  <= row3_d;
    end
  end

  assign ov_state0 = row0_q;
  assign ov_state1 = row1_q;
  assign ov_state2 = row2_q;
  assign ov_state3 = row3_q;
  assign o_busy    = (state_q == ST_RUN);
  assign o_done    = done_q;

endmodule

// File: tb/tb_p_shift_state_iter.sv
// Self-checking bench for p_shift_state_iter: directed cases plus random round trips at W=16 and W=8.
module tb_p_shift_state_iter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        start16 = 1'b0, dec16 = 1'b0, busy16, done16;
  logic [15:0] in16 [4];
  logic [15:0] out16 [4];
  logic        start8 = 1'b0, dec8 = 1'b0, busy8, done8;
  logic [7:0]  in8 [4];
  logic [7:0]  out8 [4];

  int errors = 0;
  int checks = 0;
  logic [15:0] got [4];
  int          got_lat;
  logic        got_seen;

  p_shift_state_iter u_dut16 (
    .i_clk(clk), .i_rst(rst), .i_start(start16), .i_dec(dec16),
    .iv_state0(in16[0]), .iv_state1(in16[1]), .iv_state2(in16[2]), .iv_state3(in16[3]),
    .ov_state0(out16[0]), .ov_state1(out16[1]), .ov_state2(out16[2]), .ov_state3(out16[3]),
    .o_busy(busy16), .o_done(done16)
  );

  p_shift_state_iter #(.W(8), .R1(1), .R2(3), .R3(5)) u_dut8 (
    .i_clk(clk), .i_rst(rst), .i_start(start8), .i_dec(dec8),
    .iv_state0(in8[0]), .iv_state1(in8[1]), .iv_state2(in8[2]), .iv_state3(in8[3]),
    .ov_state0(out8[0]), .ov_state1(out8[1]), .ov_state2(out8[2]), .ov_state3(out8[3]),
    .o_busy(busy8), .o_done(done8)
  );

  // Reference: whole-row rotation by the full offset, expressed with shifts.
  function automatic logic [15:0] ref_row(input logic [15:0] x, input int r, input int w, input bit dec);
    int unsigned v, m, rr;
    v  = 32'(x);
    m  = (32'd1 << w) - 32'd1;
    rr = dec ? ((w - r) % w) : r;
    return 16'(((v << rr) | (v >> (w - rr))) & m);
  endfunction

  function automatic int ref_steps(input int r, input int w);
`ifdef RECT_SHIFT_SHORTEST_EN
    return ((w - r) < r) ? (w - r) : r;
`else
    return r;
`endif
  endfunction

  function automatic int ref_lat(input int w, input int r1, input int r2, input int r3);
    int m;
    m = 1;
    if (ref_steps(r1, w) > m) m = ref_steps(r1, w);
    if (ref_steps(r2, w) > m) m = ref_steps(r2, w);
    if (ref_steps(r3, w) > m) m = ref_steps(r3, w);
    return m;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit sel, input bit st, input logic [15:0] a0, input logic [15:0] a1,
                       input logic [15:0] a2, input logic [15:0] a3, input bit dec);
    if (sel) begin
      start8 = st; dec8 = dec;
      in8[0] = a0[7:0]; in8[1] = a1[7:0]; in8[2] = a2[7:0]; in8[3] = a3[7:0];
    end else begin
      start16 = st; dec16 = dec;
      in16[0] = a0; in16[1] = a1; in16[2] = a2; in16[3] = a3;
    end
  endtask

  task automatic capture(input bit sel);
    for (int k = 0; k < 4; k++) got[k] = sel ? {8'h00, out8[k]} : out16[k];
  endtask

  // Start one operation, optionally poking i_start with junk at RUN cycle 'poke', wait for done.
  task automatic do_op(input bit sel, input logic [15:0] a0, input logic [15:0] a1,
                       input logic [15:0] a2, input logic [15:0] a3, input bit dec, input int poke);
    int n;
    drive(sel, 1'b1, a0, a1, a2, a3, dec);
    @(negedge clk);
    drive(sel, 1'b0, a0, a1, a2, a3, dec);
    chk("busy_after_load", {31'd0, sel ? busy8 : busy16}, 32'd1);
    n = 0;
    got_seen = 1'b0;
    while (!got_seen && n < 64) begin
      @(negedge clk);
      n++;
      if (n == poke) drive(sel, 1'b1, ~a0, ~a1, ~a2, ~a3, ~dec);
      else if (n == poke + 1) drive(sel, 1'b0, a0, a1, a2, a3, dec);
      got_seen = sel ? done8 : done16;
    end
    got_lat = n;
    capture(sel);
    chk("done_seen", {31'd0, got_seen}, 32'd1);
    @(negedge clk);
    chk("done_one_cycle", {31'd0, sel ? done8 : done16}, 32'd0);
    chk("idle_after_done", {31'd0, sel ? busy8 : busy16}, 32'd0);
  endtask

  initial begin
    int l16, l8, n;
    logic [15:0] orig [4];
    logic saw;
    l16 = ref_lat(16, 1, 12, 13);
    l8  = ref_lat(8, 1, 3, 5);
    for (int k = 0; k < 4; k++) begin in16[k] = 16'h0; in8[k] = 8'h0; end

    // Reset values
    repeat (2) @(negedge clk);
    chk("rst_busy", {31'd0, busy16}, 32'd0);
    chk("rst_done", {31'd0, done16}, 32'd0);
    for (int k = 0; k < 4; k++) chk("rst_row", {16'd0, out16[k]}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Directed forward
    do_op(1'b0, 16'h1234, 16'h8001, 16'h000F, 16'h0007, 1'b0, 0);
    chk("fwd_row0", {16'd0, got[0]}, 32'h1234);
    chk("fwd_row1", {16'd0, got[1]}, 32'h0003);
    chk("fwd_row2", {16'd0, got[2]}, 32'hF000);
    chk("fwd_row3", {16'd0, got[3]}, 32'hE000);
`ifdef RECT_SHIFT_SHORTEST_EN
    chk("fwd_lat", got_lat, 32'd4);
`else
    chk("fwd_lat", got_lat, 32'd13);
`endif

    // Directed inverse
    do_op(1'b0, 16'h1234, 16'h0003, 16'hF000, 16'hE000, 1'b1, 0);
    chk("inv_row0", {16'd0, got[0]}, 32'h1234);
    chk("inv_row1", {16'd0, got[1]}, 32'h8001);
    chk("inv_row2", {16'd0, got[2]}, 32'h000F);
    chk("inv_row3", {16'd0, got[3]}, 32'h0007);
    chk("inv_lat", got_lat, l16);

    // Start while busy is ignored
    do_op(1'b0, 16'h1234, 16'h8001, 16'h000F, 16'h0007, 1'b0, 3);
    chk("busy_row1", {16'd0, got[1]}, 32'h0003);
    chk("busy_row2", {16'd0, got[2]}, 32'hF000);
    chk("busy_row3", {16'd0, got[3]}, 32'hE000);
    chk("busy_lat", got_lat, l16);

    // Back-to-back: start held high through the done cycle, data switched to B meanwhile
    drive(1'b0, 1'b1, 16'h1234, 16'h8001, 16'h000F, 16'h0007, 1'b0);
    @(negedge clk);
    drive(1'b0, 1'b1, 16'h5555, 16'h0003, 16'hF000, 16'hE000, 1'b1);
    n = 0; saw = 1'b0;
    while (!saw && n < 64) begin @(negedge clk); n++; saw = done16; end
    chk("b2b_a_lat", n, l16);
    chk("b2b_a_row1", {16'd0, out16[1]}, 32'h0003);
    chk("b2b_a_row3", {16'd0, out16[3]}, 32'hE000);
    @(negedge clk);
    drive(1'b0, 1'b0, 16'h5555, 16'h0003, 16'hF000, 16'hE000, 1'b1);
    chk("b2b_b_busy", {31'd0, busy16}, 32'd1);
    n = 0; saw = 1'b0;
    while (!saw && n < 64) begin @(negedge clk); n++; saw = done16; end
    chk("b2b_b_lat", n, l16);
    chk("b2b_b_row0", {16'd0, out16[0]}, 32'h5555);
    chk("b2b_b_row1", {16'd0, out16[1]}, 32'h8001);
    chk("b2b_b_row2", {16'd0, out16[2]}, 32'h000F);
    @(negedge clk);

    // Reset mid-RUN aborts at once with no done
    drive(1'b0, 1'b1, 16'hFFFF, 16'hA5A5, 16'h3C3C, 16'h0F0F, 1'b0);
    @(negedge clk);
    drive(1'b0, 1'b0, 16'hFFFF, 16'hA5A5, 16'h3C3C, 16'h0F0F, 1'b0);
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    for (int k = 0; k < 4; k++) chk("midrst_row", {16'd0, out16[k]}, 32'd0);
    chk("midrst_busy", {31'd0, busy16}, 32'd0);
    saw = 1'b0;
    repeat (2) begin @(negedge clk); saw = saw | done16; end
    rst = 1'b0;
    repeat (l16 + 3) begin @(negedge clk); saw = saw | done16; end
    chk("midrst_no_done", {31'd0, saw}, 32'd0);
    chk("midrst_idle", {31'd0, busy16}, 32'd0);

    // Random round trips at W=16
    for (int i = 0; i < 1000; i++) begin
      for (int k = 0; k < 4; k++) orig[k] = 16'($urandom);
      do_op(1'b0, orig[0], orig[1], orig[2], orig[3], 1'b0, 0);
      chk("r16_f0", {16'd0, got[0]}, {16'd0, orig[0]});
      chk("r16_f1", {16'd0, got[1]}, {16'd0, ref_row(orig[1], 1, 16, 1'b0)});
      chk("r16_f2", {16'd0, got[2]}, {16'd0, ref_row(orig[2], 12, 16, 1'b0)});
      chk("r16_f3", {16'd0, got[3]}, {16'd0, ref_row(orig[3], 13, 16, 1'b0)});
      chk("r16_flat", got_lat, l16);
      do_op(1'b0, got[0], got[1], got[2], got[3], 1'b1, 0);
      for (int k = 0; k < 4; k++) chk("r16_trip", {16'd0, got[k]}, {16'd0, orig[k]});
      chk("r16_ilat", got_lat, l16);
    end

    // Random round trips at W=8
    for (int i = 0; i < 1000; i++) begin
      for (int k = 0; k < 4; k++) orig[k] = {8'h00, 8'($urandom)};
      do_op(1'b1, orig[0], orig[1], orig[2], orig[3], 1'b0, 0);
      chk("r8_f1", {16'd0, got[1]}, {16'd0, ref_row(orig[1], 1, 8, 1'b0)});
      chk("r8_f2", {16'd0, got[2]}, {16'd0, ref_row(orig[2], 3, 8, 1'b0)});
      chk("r8_f3", {16'd0, got[3]}, {16'd0, ref_row(orig[3], 5, 8, 1'b0)});
      chk("r8_flat", got_lat, l8);
      do_op(1'b1, got[0], got[1], got[2], got[3], 1'b1, 0);
      for (int k = 0; k < 4; k++) chk("r8_trip", {16'd0, got[k]}, {16'd0, orig[k]});
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
